// File: rtl/present_sbox_sched.sv
// Round controller for the nibble-serial masked PRESENT-80 core: schedules the shared S-box gadget.
// Optional macro SBOX_CLKGATE_EN: gate_en follows gadget activity instead of being held high.
module present_sbox_sched #(
    parameter int LAT    = 2,
    parameter int ROUNDS = 31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rnd_valid,
    output logic       rnd_take,
    output logic       sb_valid,
    output logic       sb_src,
    output logic [3:0] sb_idx,
    output logic       wb_en,
    output logic       wb_src,
    output logic [3:0] wb_idx,
    output logic       ark_en,
    output logic       key_rot_en,
    output logic       player_en,
    output logic [4:0] round,
    output logic       busy,
    output logic       done,
    output logic       gate_en
);

    typedef enum logic [3:0] {
        S_IDLE, S_ARK, S_KROT, S_SBOX, S_KEYSB, S_DRAIN, S_PLAYER, S_FINAL, S_DONE
    } state_t;

    state_t     state_reg;
    logic [3:0] idx_reg;
    logic       src_reg;
    logic [2:0] drain_cnt_reg;
    logic [4:0] round_reg;
    logic       ark_reg;
    logic       krot_reg;
    logic       player_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       issue;

    logic [LAT-1:0] pipe_v_reg;
    logic [LAT-1:0] pipe_src_reg;
    logic [3:0]     pipe_idx_reg [LAT];

    // An issue is the same-cycle handshake with the PRNG; it cannot be registered.
    assign issue      = ((state_reg == S_SBOX) || (state_reg == S_KEYSB)) && rnd_valid;
    assign sb_valid   = issue;
    assign rnd_take   = issue;
    assign sb_src     = src_reg;
    assign sb_idx     = idx_reg;
    assign ark_en     = ark_reg;
    assign key_rot_en = krot_reg;
    assign player_en  = player_reg;
    assign round      = round_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            idx_reg       <= 4'd0;
            src_reg       <= 1'b0;
            drain_cnt_reg <= 3'd0;
            round_reg     <= 5'd0;
            ark_reg       <= 1'b0;
            krot_reg      <= 1'b0;
            player_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            ark_reg    <= 1'b0;
            krot_reg   <= 1'b0;
            player_reg <= 1'b0;
            done_reg   <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg <= S_ARK;
                        ark_reg   <= 1'b1;
                        round_reg <= 5'd1;
                        busy_reg  <= 1'b1;
                    end
                end
                S_ARK: begin
                    state_reg <= S_KROT;
                    krot_reg  <= 1'b1;
                end
                S_KROT: begin
                    state_reg <= S_SBOX;
                    idx_reg   <= 4'd0;
                    src_reg   <= 1'b0;
                end
                S_SBOX: begin
                    if (rnd_valid) begin
                        if (idx_reg == 4'd15) begin
                            // The key nibble reuses index 15, so only the source flips.
                            state_reg <= S_KEYSB;
                            src_reg   <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + 4'd1;
                        end
                    end
                end
                S_KEYSB: begin
                    if (rnd_valid) begin
                        state_reg     <= S_DRAIN;
                        drain_cnt_reg <= 3'(LAT - 1);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_reg == 3'd0) begin
                        state_reg  <= S_PLAYER;
                        player_reg <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - 3'd1;
                    end
                end
                S_PLAYER: begin
                    ark_reg <= 1'b1;
                    if (round_reg == 5'(ROUNDS)) begin
                        state_reg <= S_FINAL;
                    end else begin
                        state_reg <= S_ARK;
                        round_reg <= round_reg + 5'd1;
                    end
                end
                S_FINAL: begin
                    state_reg <= S_DONE;
                    done_reg  <= 1'b1;
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    round_reg <= 5'd0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Gadget-latency delay line: runs freely so stalls never stretch write-back timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v_reg   <= '0;
            pipe_src_reg <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_idx_reg[i] <= 4'd0;
            end
        end else begin
            pipe_v_reg[0]   <= issue;
            pipe_src_reg[0] <= src_reg;
            pipe_idx_reg[0] <= idx_reg;
            for (int i = 1; i < LAT; i++) begin
                pipe_v_reg[i]   <= pipe_v_reg[i-1];
                pipe_src_reg[i] <= pipe_src_reg[i-1];
                pipe_idx_reg[i] <= pipe_idx_reg[i-1];
            end
        end
    end

    assign wb_en  = pipe_v_reg[LAT-1];
    assign wb_src = pipe_src_reg[LAT-1];
    assign wb_idx = pipe_idx_reg[LAT-1];

`ifdef SBOX_CLKGATE_EN
    assign gate_en = issue | (|pipe_v_reg);
`else
    logic gate_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_reg <= 1'b0;
        end else begin
            gate_reg <= 1'b1;
        end
    end

    assign gate_en = gate_reg;
`endif

endmodule

// File: doc/present_sbox_sched.md
Name: present_sbox_sched

Overview:
- Round controller for the nibble-serial first-order masked PRESENT-80 encryption core.
- Sequences the single shared masked S-box gadget (4-bit, 2 shares, 4 fresh random bits per use) between two requesters: the 16 state nibbles and the key-schedule top nibble.
- Issues one nibble per cycle, tracks in-flight results through the gadget latency, and emits strobes for write-back, AddRoundKey, pLayer and key update.
- Owns the randomness handshake with the PRNG.

Parameters:
- LAT, 2, gadget latency in cycles, from input sample to valid output; legal range 1..4.
- ROUNDS, 31, number of full PRESENT rounds.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin encryption; sampled only in IDLE
- rnd_valid  in  1  PRNG has 4 fresh bits available
- rnd_take  out  1  consume randomness this cycle; equals sb_valid
- sb_valid  out  1  gadget input sampled this cycle
- sb_src  out  1  0 = state nibble, 1 = key nibble
- sb_idx  out  4  nibble index being issued
- wb_en  out  1  gadget output valid; write it back
- wb_src  out  1  sb_src delayed by LAT
- wb_idx  out  4  sb_idx delayed by LAT
- ark_en  out  1  AddRoundKey strobe
- key_rot_en  out  1  rotate 80-bit key register left by 61
- player_en  out  1  pLayer strobe; key counter XOR into bits 19:15 in the same cycle
- round  out  5  current round, 1..31; 0 in IDLE
- busy  out  1  high in any state except IDLE
- done  out  1  single-cycle completion pulse
- gate_en  out  1  clock-gate enable for the gadget

Behaviour:
- Reset values: all outputs 0, state IDLE, delay pipeline valid bits cleared.
- States and transitions:
  - IDLE: on start go to ARK with round=1.
  - ARK: ark_en=1 for 1 cycle, then KROT.
  - KROT: key_rot_en=1 for 1 cycle, then SBOX with idx=0.
  - SBOX: sb_src=0, sb_idx=idx. Issue when rnd_valid=1 (sb_valid=rnd_take=1, idx+1). When rnd_valid=0, no issue and idx holds. After idx 15 is issued, go to KEYSB.
  - KEYSB: sb_src=1, sb_idx=15. Issue when rnd_valid=1, then go to DRAIN; stall otherwise.
  - DRAIN: exactly LAT cycles, then PLAYER.
  - PLAYER: player_en=1 for 1 cycle. If round==ROUNDS go to FINAL; else round+1 and go to ARK.
  - FINAL: ark_en=1 for 1 cycle, then DONE.
  - DONE: done=1 for 1 cycle, then IDLE with round=0.
- Write-back: wb_en/wb_src/wb_idx equal sb_valid/sb_src/sb_idx delayed by exactly LAT cycles through a shift register. The shift register is independent of stalls, so the last write-back lands in the final DRAIN cycle.
- No stalls, LAT=2: 22 cycles per round. start at cycle 0 gives the first ark_en in cycle 1, the final ark_en in cycle 683 and done in cycle 684.
- start while busy is ignored; start and done in the same cycle cannot occur because start is only sampled in IDLE.
- rnd_valid is ignored outside SBOX/KEYSB; rnd_take is never asserted outside an issue.
- sb_idx and sb_src hold their last value while stalled; they are don't-care while sb_valid=0.
- Reset mid-operation: immediate return to IDLE, in-flight write-backs dropped, no wb_en after reset release.

Optional Feature:
- SBOX_CLKGATE_EN defined: gate_en = sb_valid OR any delay-pipeline valid bit; low in IDLE, ARK, KROT, PLAYER, FINAL and DONE, and after DRAIN completes.
- SBOX_CLKGATE_EN undefined: gate_en is constant 1 after reset release (0 during reset).

Test Plan:
- rnd_valid=1 constant, LAT=2, start pulse at cycle 0 -> 16 state + 1 key issue per round, done in cycle 684 and only there, round reaches 31, 32 ark_en pulses, 31 player_en, 31 key_rot_en.
- LAT=2, rnd_valid low for 3 cycles when idx=5 in round 1 -> sb_idx holds 5, no rnd_take in those cycles, wb_idx sequence has no gaps or duplicates, done shifts to cycle 687.
- Each issue (idx i, src s) at cycle c -> wb_en=1, wb_idx=i, wb_src=s at c+LAT; exercise with LAT=1 and LAT=4 -> per-round length 21 and 24.
- rst_n low in round 3 SBOX at idx 8 with writes in flight -> all outputs 0 asynchronously, no wb_en after release, new start yields a full clean run.
- start re-pulsed while busy in round 10 -> no effect, done timing unchanged.
- With SBOX_CLKGATE_EN -> gate_en=0 in IDLE and in PLAYER cycles, 1 from first issue through final write-back; without the macro -> gate_en constantly 1.
